// File: rtl/tl_mem_slave.sv
// Single-beat TileLink-style memory slave: accepts Get/PutFullData, answers after LATENCY+1 edges.
// Responses are driven from a registered output stage that follows the FSM state by one cycle.
module tl_mem_slave #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [54:0] a_channel,
  output logic [46:0] d_channel,
  output logic [7:0]  err_count
);

  localparam int unsigned AddrIdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0]  LatInit  = 2'(LATENCY - 1);
  localparam logic [2:0]  OpPut    = 3'd0;
  localparam logic [2:0]  OpGet    = 3'd4;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  // Request field decode
  logic [2:0]  a_opcode, a_param, a_size;
  logic [1:0]  a_source;
  logic [9:0]  a_address;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_legal;
  logic        accept;
  logic        unused_a_ready;

  assign a_opcode       = a_channel[54:52];
  assign a_param        = a_channel[51:49];
  assign a_size         = a_channel[48:46];
  assign a_source       = a_channel[45:44];
  assign a_address      = a_channel[43:34];
  assign a_data         = a_channel[33:2];
  assign a_valid        = a_channel[1];
  assign unused_a_ready = a_channel[0];

  assign a_legal = ((a_opcode == OpGet) || (a_opcode == OpPut)) && (a_param == 3'd0) &&
                   (a_size == 3'd5) && (32'(a_address) < MEM_DEPTH);
  assign accept  = (state_q == StIdle) && a_valid && !reset;

  // Latched request
  logic [2:0] opcode_q;
  logic [2:0] size_q;
  logic [1:0] source_q;
  logic [9:0] addr_q;
  logic       legal_q;

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] rdata;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (a_valid) begin
          state_d = StWait;
          cnt_d   = LatInit;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      opcode_q <= a_opcode;
      size_q   <= a_size;
      source_q <= a_source;
      addr_q   <= a_address;
      legal_q  <= a_legal;
    end
  end

  // Memory is never reset; only legal puts write it
  always_ff @(posedge clk) begin
    if (accept && a_legal && (a_opcode == OpPut)) begin
      mem[AddrIdxW'(a_address)] <= a_data;
    end
  end

  assign rdata = mem[AddrIdxW'(addr_q)];

  // Output logic, registered below so d_channel lags the state by one edge
  logic [46:0] d_channel_d, d_channel_q;
  logic [7:0]  err_d, err_q;

  always_comb begin
    d_channel_d = '0;
    err_d       = err_q;
    unique case (state_q)
      StIdle: d_channel_d[0] = 1'b1;
      StWait: d_channel_d = '0;
      StResp: begin
        d_channel_d[46:44] = (opcode_q == OpGet) ? 3'd1 : 3'd0;
        d_channel_d[41:37] = {2'b00, size_q};
        d_channel_d[36:35] = source_q;
        d_channel_d[34]    = !legal_q;
        d_channel_d[33:2]  = (legal_q && (opcode_q == OpGet)) ? rdata : 32'h0;
        d_channel_d[1]     = 1'b1;
        if (!legal_q && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
      end
      default: d_channel_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_channel_q <= '0;
      err_q       <= 8'd0;
    end else begin
      d_channel_q <= d_channel_d;
      err_q       <= err_d;
    end
  end

  assign d_channel = d_channel_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_tl_mem_slave.sv
// Directed bench for tl_mem_slave: vector table on a LATENCY=1 instance plus
// hand-written sequences for back-to-back, reset abort (LATENCY=3) and err_count saturation.
module tb_tl_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r1, r3;
  logic [54:0] a1, a3;
  logic [46:0] d1, d3;
  logic [7:0]  e1, e3;

  tl_mem_slave #(.MEM_DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk       (clk),
    .reset     (r1),
    .a_channel (a1),
    .d_channel (d1),
    .err_count (e1)
  );

  tl_mem_slave #(.MEM_DEPTH(1024), .LATENCY(3)) u_dut3 (
    .clk       (clk),
    .reset     (r3),
    .a_channel (a3),
    .d_channel (d3),
    .err_count (e3)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  prm;
    logic [2:0]  sz;
    logic [1:0]  src;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [2:0]  eop;
    logic        eerr;
    logic [31:0] edata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [54:0] req(input logic [2:0] op, input logic [2:0] prm,
                                      input logic [2:0] sz, input logic [1:0] src,
                                      input logic [9:0] addr, input logic [31:0] data);
    return {op, prm, sz, src, addr, data, 1'b1, 1'b0};
  endfunction

  function automatic logic [46:0] rsp(input logic [2:0] op, input logic [4:0] sz,
                                      input logic [1:0] src, input logic err,
                                      input logic [31:0] data);
    return {op, 2'b00, sz, src, err, data, 1'b1, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_errs;
  int vcount;

  initial begin
    //            op    prm   sz    src   addr     data          eop   eerr  edata
    vecs[0]  = '{3'd0, 3'd0, 3'd5, 2'd1, 10'h005, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0};
    vecs[1]  = '{3'd4, 3'd0, 3'd5, 2'd0, 10'h005, 32'h0,        3'd1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{3'd4, 3'd0, 3'd0, 2'd0, 10'h000, 32'h0,        3'd1, 1'b1, 32'h0};
    vecs[3]  = '{3'd0, 3'd0, 3'd5, 2'd2, 10'h003, 32'hCAFEF00D, 3'd0, 1'b0, 32'h0};
    vecs[4]  = '{3'd2, 3'd0, 3'd5, 2'd3, 10'h003, 32'h12345678, 3'd0, 1'b1, 32'h0};
    vecs[5]  = '{3'd4, 3'd0, 3'd5, 2'd1, 10'h003, 32'h0,        3'd1, 1'b0, 32'hCAFEF00D};
    vecs[6]  = '{3'd0, 3'd0, 3'd5, 2'd0, 10'h007, 32'hA5A5A5A5, 3'd0, 1'b0, 32'h0};
    vecs[7]  = '{3'd0, 3'd1, 3'd5, 2'd2, 10'h007, 32'h11111111, 3'd0, 1'b1, 32'h0};
    vecs[8]  = '{3'd4, 3'd0, 3'd5, 2'd3, 10'h007, 32'h0,        3'd1, 1'b0, 32'hA5A5A5A5};
    vecs[9]  = '{3'd4, 3'd2, 3'd5, 2'd1, 10'h007, 32'h0,        3'd1, 1'b1, 32'h0};
    vecs[10] = '{3'd0, 3'd0, 3'd5, 2'd2, 10'h3FF, 32'h0BADF00D, 3'd0, 1'b0, 32'h0};
    vecs[11] = '{3'd4, 3'd0, 3'd4, 2'd0, 10'h3FF, 32'h0,        3'd1, 1'b1, 32'h0};
    vecs[12] = '{3'd4, 3'd0, 3'd5, 2'd1, 10'h3FF, 32'h0,        3'd1, 1'b0, 32'h0BADF00D};
    vecs[13] = '{3'd1, 3'd0, 3'd5, 2'd3, 10'h3FF, 32'hFFFFFFFF, 3'd0, 1'b1, 32'h0};
    vecs[14] = '{3'd4, 3'd0, 3'd5, 2'd0, 10'h3FF, 32'h0,        3'd1, 1'b0, 32'h0BADF00D};

    r1 = 1'b1;
    r3 = 1'b1;
    a1 = '0;
    a3 = '0;
    exp_errs = 0;

    // Reset state
    repeat (3) step();
    check("reset_d1", d1, 47'h0);
    check("reset_err1", e1, 8'd0);
    check("reset_d3", d3, 47'h0);
    r1 = 1'b0;
    r3 = 1'b0;
    step();
    check("ready_after_reset1", d1, 47'h1);
    check("ready_after_reset3", d3, 47'h1);

    // Table-driven transactions, back to back on LATENCY=1
    for (int i = 0; i < NV; i++) begin
      a1 = req(vecs[i].op, vecs[i].prm, vecs[i].sz, vecs[i].src, vecs[i].addr, vecs[i].data);
      step();
      a1 = '0;
      step();
      check($sformatf("vec%0d_early_valid", i), d1[1], 1'b0);
      step();
      check($sformatf("vec%0d_resp", i), d1,
            rsp(vecs[i].eop, {2'b00, vecs[i].sz}, vecs[i].src, vecs[i].eerr, vecs[i].edata));
      if (vecs[i].eerr) exp_errs++;
      check($sformatf("vec%0d_err_count", i), e1, 8'(exp_errs));
    end
    step();
    check("idle_outputs", d1, 47'h1);

    // Request held during WAIT/RESP is ignored until the FSM is back in IDLE
    a1 = req(3'd0, 3'd0, 3'd5, 2'd1, 10'h009, 32'h00000001);
    step();
    a1 = req(3'd4, 3'd0, 3'd5, 2'd2, 10'h009, 32'h0);
    step();
    check("held_wait_valid", d1[1], 1'b0);
    step();
    check("held_first_resp", d1, rsp(3'd0, 5'd5, 2'd1, 1'b0, 32'h0));
    step();
    a1 = '0;
    check("held_gap_valid", d1[1], 1'b0);
    step();
    check("held_second_early", d1[1], 1'b0);
    step();
    check("held_second_resp", d1, rsp(3'd1, 5'd5, 2'd2, 1'b0, 32'h00000001));
    step();
    check("held_no_third", d1[1], 1'b0);

    // LATENCY=3: reset one cycle after accepting a Put abandons the response
    a3 = req(3'd0, 3'd0, 3'd5, 2'd1, 10'h020, 32'h5555AAAA);
    step();
    a3 = '0;
    r3 = 1'b1;
    step();
    check("abort_d_in_reset", d3, 47'h0);
    r3 = 1'b0;
    step();
    check("abort_ready_back", d3, 47'h1);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (d3[1]) vcount++;
    end
    check("abort_no_valid", 64'(vcount), 64'd0);
    check("abort_err3", e3, 8'd0);

    // Put survives the reset; LATENCY=3 gives d_valid on the 4th edge after acceptance
    a3 = req(3'd4, 3'd0, 3'd5, 2'd1, 10'h020, 32'h0);
    step();
    a3 = '0;
    step();
    step();
    step();
    check("lat3_not_yet", d3[1], 1'b0);
    step();
    check("lat3_resp", d3, rsp(3'd1, 5'd5, 2'd1, 1'b0, 32'h5555AAAA));

    // err_count saturation
    for (int i = 0; i < 256; i++) begin
      a1 = req(3'd4, 3'd0, 3'd0, 2'd0, 10'h000, 32'h0);
      step();
      a1 = '0;
      step();
      step();
    end
    check("sat_last_resp", d1, rsp(3'd1, 5'd0, 2'd0, 1'b1, 32'h0));
    check("sat_err_count", e1, 8'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_mem_slave.md
TL_MEM_SLAVE -- requirements
Module: tl_mem_slave

Interface
REQ-001 Parameter MEM_DEPTH, 1024, number of 32-bit words; addresses >= MEM_DEPTH are out of range.
REQ-002 Parameter LATENCY, 1, cycles from request acceptance to d_valid; legal values 1..3.
REQ-003 Clocking SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-004 Port clk  input  1  clock; all logic on rising edge.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port a_channel  input  55  request: opcode[54:52] param[51:49] size[48:46] source[45:44] address[43:34] data[33:2] valid[1] ready[0].
REQ-007 Port d_channel  output  47  response: opcode[46:44] param[43:42] size[41:37] source[36:35] error[34] data[33:2] valid[1] ready[0].
REQ-008 Port err_count  output  8  count of responses with d_error=1, saturating at 255.

Function
REQ-009 The block SHALL be a three-state FSM: IDLE, WAIT, RESP.
REQ-010 In IDLE, d_channel[0] (slave ready) SHALL be 1; in WAIT and RESP it SHALL be 0.
REQ-011 A request SHALL be accepted in IDLE on any edge where a_channel[1]=1; a_channel[0] is ignored.
REQ-012 On acceptance, opcode, param, size, source, address and data SHALL be latched, and the FSM SHALL go to WAIT with latency counter = LATENCY-1.
REQ-013 Legal requests: opcode 4 (Get) or 0 (PutFullData), param 0, size 5, address < MEM_DEPTH; every other request is an error request.
REQ-014 A legal PutFullData SHALL write a_data to mem[address] on the acceptance edge; error requests SHALL never write memory.
REQ-015 A legal Get SHALL read mem[address] after any write on the same edge, so a Get following a Put to the same address returns the new data.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 0 (LATENCY=1 means RESP immediately).
REQ-017 RESP SHALL last exactly one cycle: d_valid=1, then return to IDLE.
REQ-018 Total latency: d_valid SHALL be high on edge N+LATENCY+1 after acceptance edge N; for LATENCY=1, acceptance-to-d_valid is 2 edges.
REQ-019 Response d_opcode SHALL be 1 (AccessAckData) for request opcode 4, and 0 (AccessAck) for every other request opcode.
REQ-020 d_param SHALL be 0; d_size SHALL be the request size zero-extended to 5 bits; d_source SHALL echo a_source.
REQ-021 d_data SHALL be the read word for a legal Get, and 0 for a Put or error request.
REQ-022 d_error SHALL be 1 for an error request, else 0.
REQ-023 Outside RESP, d_valid, d_error and d_data SHALL be 0.
REQ-024 err_count SHALL increment by 1 in the RESP cycle when d_error=1, and hold at 255.
REQ-025 A request with a_channel[1]=1 arriving in WAIT or RESP SHALL be ignored: no latch, no write, no response.
REQ-026 A request presented in the cycle after RESP (FSM in IDLE) SHALL be accepted normally, allowing back-to-back transactions.

Reset
REQ-027 During reset, d_channel SHALL be all zeros, err_count SHALL be 0 and the FSM SHALL be IDLE.
REQ-028 d_channel[0] SHALL become 1 on the first edge after reset deasserts.
REQ-029 Reset SHALL NOT clear memory contents.
REQ-030 Reset asserted in WAIT or RESP SHALL abandon the pending response with no d_valid; a Put already accepted stays written.

Verification
REQ-031 LATENCY=1: Put addr 0x005, data 0xDEADBEEF, size 5, source 1 -> two edges later d_valid=1, d_opcode=0, d_error=0, d_source=1, d_data=0.
REQ-032 Get addr 0x005, size 5 -> d_opcode=1, d_data=0xDEADBEEF, d_error=0, d_size=5.
REQ-033 Get with size 0 (opcode 4, all other fields 0) -> d_opcode=1, d_error=1, d_data=0; err_count increments to 1.
REQ-034 Opcode 2 to addr 0x003 with data 0x12345678 -> d_opcode=0, d_error=1; a following Get of 0x003 returns the prior contents unchanged.
REQ-035 Second request with a_valid=1 held during WAIT -> only one response produced; the held request is accepted in the IDLE cycle after RESP.
REQ-036 LATENCY=3, reset pulsed one cycle after acceptance -> no d_valid, d_channel=0 during reset, ready=1 on the next edge; 256 error requests -> err_count=255.
